d_e_pipe_reg: RTL and testbench

//  D->E pipeline register feeding the E-stage decoder/ALU: latches instr, pc, operand data, Tnew and valid.

---
 rtl/d_e_pipe_reg_pkg.sv | 36 +++
 rtl/d_e_pipe_reg_if.sv | 48 ++++
 rtl/d_e_pipe_reg_operand_refresh.sv | 38 +++
 rtl/d_e_pipe_reg.sv | 128 ++++++++++++
 tb/tb_d_e_pipe_reg.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/d_e_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : d_e_pipe_reg_pkg
// Brief   : Shared constants and field helpers for the D->E pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
package d_e_pipe_reg_pkg;

    // Architectural nop inserted as a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Width of the Tnew (cycles-until-result) fields
    localparam int TNEW_W = 2;

    // pc presented on pc_E after reset
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Register-specifier field positions inside an instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // Hard-wired zero register; never refreshed from write-back
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [4:0] rs_field(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rt_field(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage : d_e_pipe_reg_pkg
`default_nettype wire

// File: rtl/d_e_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module  : d_e_pipe_reg_if
// Brief   : D-stage, W-stage and E-stage signal bundle around the D->E
//           pipeline register. master = pipeline side driving D/W, slave =
//           the register itself.
// Revision: 1.0 - initial release
// ============================================================================
interface d_e_pipe_reg_if #(
    parameter int TNEW_W = 2
);
    // D-stage side
    logic [31:0]       instr_D;
    logic [31:0]       pc_D;
    logic [31:0]       rs_data_D;
    logic [31:0]       rt_data_D;
    logic [TNEW_W-1:0] Tnew_D;
    logic              valid_D;
    logic              stall_D;
    // E-stage control
    logic              hold_E;
    // W-stage write-back
    logic              we_W;
    logic [4:0]        reg_addr_W;
    logic [31:0]       wdata_W;
    // E-stage side
    logic [31:0]       instr_E;
    logic [31:0]       pc_E;
    logic [31:0]       rs_data_E;
    logic [31:0]       rt_data_E;
    logic [TNEW_W-1:0] Tnew_E;
    logic [TNEW_W-1:0] Tnew_to_M;
    logic              valid_E;

    modport master (
        output instr_D, pc_D, rs_data_D, rt_data_D, Tnew_D, valid_D, stall_D,
        output hold_E, we_W, reg_addr_W, wdata_W,
        input  instr_E, pc_E, rs_data_E, rt_data_E, Tnew_E, Tnew_to_M, valid_E
    );

    modport slave (
        input  instr_D, pc_D, rs_data_D, rt_data_D, Tnew_D, valid_D, stall_D,
        input  hold_E, we_W, reg_addr_W, wdata_W,
        output instr_E, pc_E, rs_data_E, rt_data_E, Tnew_E, Tnew_to_M, valid_E
    );

endinterface : d_e_pipe_reg_if
`default_nettype wire

// File: rtl/d_e_pipe_reg_operand_refresh.sv
`default_nettype none
// ============================================================================
// Module  : d_e_pipe_reg_operand_refresh
// Brief   : Next-value selection for one E-stage operand register: refresh
//           from W while held, zero on bubble, otherwise load from D.
// Revision: 1.0 - initial release
// ============================================================================
module d_e_pipe_reg_operand_refresh
    import d_e_pipe_reg_pkg::*;
(
    input  wire logic        hold,
    input  wire logic        stall,
    input  wire logic        we_W,
    input  wire logic [4:0]  reg_addr_W,
    input  wire logic [4:0]  src_field,
    input  wire logic [31:0] wdata_W,
    input  wire logic [31:0] cur_data,
    input  wire logic [31:0] d_data,
    output logic      [31:0] next_data
);

    logic w_match;

    // W write-back targets the register this operand was read from ($0 excluded)
    assign w_match = we_W && (reg_addr_W != REG_ZERO) && (reg_addr_W == src_field);

    // Priority hold > stall > load
    always_comb begin
        next_data = d_data;
        if (hold) begin
            next_data = w_match ? wdata_W : cur_data;
        end else if (stall) begin
            next_data = '0;
        end
    end

endmodule : d_e_pipe_reg_operand_refresh
`default_nettype wire

// File: rtl/d_e_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : d_e_pipe_reg
// Brief   : D->E pipeline register. Loads D-stage fields, inserts a nop
//           bubble on a D stall, freezes while E is held (refreshing frozen
//           operands from W), and supplies a saturating Tnew-1 for E/M.
//           Optional feature macro: D_E_BUBBLE_CNT_EN adds a 32-bit
//           bubble_cnt output counting inserted bubbles.
// Revision: 1.0 - initial release
// ============================================================================
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = d_e_pipe_reg_pkg::RESET_PC,
    parameter int          TNEW_W   = d_e_pipe_reg_pkg::TNEW_W
) (
    input  wire logic clk,
    input  wire logic reset_n,
    d_e_pipe_reg_if.slave bus
`ifdef D_E_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0]       r_instr;
    logic [31:0]       r_pc;
    logic [31:0]       r_rs_data;
    logic [31:0]       r_rt_data;
    logic [TNEW_W-1:0] r_tnew;
    logic              r_valid;

    logic [31:0]       w_rs_next;
    logic [31:0]       w_rt_next;
    logic              w_bubble;

    // A bubble is only inserted when E is free to advance
    assign w_bubble = bus.stall_D && !bus.hold_E;

    d_e_pipe_reg_operand_refresh u_rs_refresh (
        .hold       (bus.hold_E),
        .stall      (bus.stall_D),
        .we_W       (bus.we_W),
        .reg_addr_W (bus.reg_addr_W),
        .src_field  (rs_field(r_instr)),
        .wdata_W    (bus.wdata_W),
        .cur_data   (r_rs_data),
        .d_data     (bus.rs_data_D),
        .next_data  (w_rs_next)
    );

    d_e_pipe_reg_operand_refresh u_rt_refresh (
        .hold       (bus.hold_E),
        .stall      (bus.stall_D),
        .we_W       (bus.we_W),
        .reg_addr_W (bus.reg_addr_W),
        .src_field  (rt_field(r_instr)),
        .wdata_W    (bus.wdata_W),
        .cur_data   (r_rt_data),
        .d_data     (bus.rt_data_D),
        .next_data  (w_rt_next)
    );

    // Control/identity fields: freeze on hold, nop on bubble (pc still follows D), else load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_tnew  <= '0;
            r_valid <= 1'b0;
        end else if (bus.hold_E) begin
            r_instr <= r_instr;
            r_pc    <= r_pc;
            r_tnew  <= r_tnew;
            r_valid <= r_valid;
        end else if (bus.stall_D) begin
            r_instr <= NOP_INSTR;
            r_pc    <= bus.pc_D;
            r_tnew  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_instr <= bus.instr_D;
            r_pc    <= bus.pc_D;
            r_tnew  <= bus.Tnew_D;
            r_valid <= bus.valid_D;
        end
    end

    // Operand registers take the value chosen by their refresh mux
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else begin
            r_rs_data <= w_rs_next;
            r_rt_data <= w_rt_next;
        end
    end

`ifdef D_E_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Count inserted bubbles; natural wrap at 32 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    logic w_unused_bubble;
    assign w_unused_bubble = w_bubble;
`endif

    assign bus.instr_E   = r_instr;
    assign bus.pc_E      = r_pc;
    assign bus.rs_data_E = r_rs_data;
    assign bus.rt_data_E = r_rt_data;
    assign bus.Tnew_E    = r_tnew;
    assign bus.valid_E   = r_valid;
    // Tnew one stage later, saturating at zero
    assign bus.Tnew_to_M = (r_tnew == '0) ? '0 : (r_tnew - TNEW_W'(1));

endmodule : d_e_pipe_reg
`default_nettype wire

// File: tb/tb_d_e_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_d_e_pipe_reg
// Brief   : Self-checking bench for d_e_pipe_reg: directed scenarios then
//           randomized traffic against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_d_e_pipe_reg;

    localparam int TW = 2;

    logic clk;
    logic reset_n;

    d_e_pipe_reg_if #(.TNEW_W(TW)) bus ();

`ifdef D_E_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    d_e_pipe_reg #(.RESET_PC(32'h0000_3000), .TNEW_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef D_E_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]   m_instr, m_pc, m_rs, m_rt, m_cnt;
    logic [TW-1:0] m_tnew;
    logic          m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_instr = 32'h0;
        m_pc    = 32'h0000_3000;
        m_rs    = 32'h0;
        m_rt    = 32'h0;
        m_tnew  = '0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // One clock edge of the register, expressed as the behavioural rules
    task automatic model_edge();
        if (bus.hold_E) begin
            if (bus.we_W && bus.reg_addr_W != 5'd0) begin
                if (bus.reg_addr_W == m_instr[25:21]) m_rs = bus.wdata_W;
                if (bus.reg_addr_W == m_instr[20:16]) m_rt = bus.wdata_W;
            end
        end else if (bus.stall_D) begin
            m_instr = 32'h0;
            m_rs    = 32'h0;
            m_rt    = 32'h0;
            m_tnew  = '0;
            m_valid = 1'b0;
            m_pc    = bus.pc_D;
            m_cnt   = m_cnt + 32'd1;
        end else begin
            m_instr = bus.instr_D;
            m_pc    = bus.pc_D;
            m_rs    = bus.rs_data_D;
            m_rt    = bus.rt_data_D;
            m_tnew  = bus.Tnew_D;
            m_valid = bus.valid_D;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_m;
        exp_m = (int'(m_tnew) == 0) ? 0 : int'(m_tnew) - 1;
        check({tag, ".instr_E"},   bus.instr_E,   m_instr);
        check({tag, ".pc_E"},      bus.pc_E,      m_pc);
        check({tag, ".rs_data_E"}, bus.rs_data_E, m_rs);
        check({tag, ".rt_data_E"}, bus.rt_data_E, m_rt);
        check({tag, ".Tnew_E"},    32'(bus.Tnew_E),    32'(m_tnew));
        check({tag, ".Tnew_to_M"}, 32'(bus.Tnew_to_M), 32'(exp_m));
        check({tag, ".valid_E"},   32'(bus.valid_E),   32'(m_valid));
`ifdef D_E_BUBBLE_CNT_EN
        check({tag, ".bubble_cnt"}, bubble_cnt, m_cnt);
`endif
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [TW-1:0] tnew, input logic valid,
                         input logic stall, input logic hold,
                         input logic we, input logic [4:0] addr, input logic [31:0] wdata);
        bus.instr_D    = instr;
        bus.pc_D       = pc;
        bus.rs_data_D  = rs;
        bus.rt_data_D  = rt;
        bus.Tnew_D     = tnew;
        bus.valid_D    = valid;
        bus.stall_D    = stall;
        bus.hold_E     = hold;
        bus.we_W       = we;
        bus.reg_addr_W = addr;
        bus.wdata_W    = wdata;
    endtask

    // Advance one edge, update the model, check everything 1ns later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Async reset pulse between edges; cleared state must appear without a clock
    task automatic async_reset_pulse(input string tag);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        drive(32'h0, 32'h0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Load an add
        drive(32'h0123_4020, 32'h3004, 32'h1111_0000, 32'h2222_0000, 2'd1, 1'b1,
              1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("load");
        check("load.instr_direct", bus.instr_E, 32'h0123_4020);
        check("load.tnew_to_m_direct", 32'(bus.Tnew_to_M), 32'd0);

        // Stall inserts a bubble with pc from D
        drive(32'h0123_4020, 32'h3008, 32'h5, 32'h6, 2'd2, 1'b1,
              1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step("stall");
        check("stall.pc_direct", bus.pc_E, 32'h3008);

        // Load instr with rs=8, rt=9, then hold with W writing $8
        drive(32'h0109_4020, 32'h300C, 32'h1111_1111, 32'h2222_2222, 2'd2, 1'b1,
              1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("load_rs8");
        drive(32'hFFFF_FFFF, 32'h4000, 32'h0, 32'h0, 2'd3, 1'b1,
              1'b0, 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF);
        step("hold_refresh");
        check("hold_refresh.rs_direct", bus.rs_data_E, 32'hDEAD_BEEF);
        check("hold_refresh.instr_direct", bus.instr_E, 32'h0109_4020);

        // Hold beats stall, then release into a bubble
        drive(32'h0, 32'h5000, 32'h0, 32'h0, 2'd0, 1'b1,
              1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        step("hold_vs_stall");
        bus.hold_E = 1'b0;
        step("release_bubble");

        // $0 guard: instr with rs=rt=0, hold and write $0
        drive(32'h0000_0020, 32'h3010, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'd3, 1'b1,
              1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("load_zero_regs");
        drive(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0,
              1'b0, 1'b1, 1'b1, 5'd0, 32'h1234_5678);
        step("zero_guard");
        check("zero_guard.rs_direct", bus.rs_data_E, 32'hAAAA_AAAA);

        // Async reset in the middle of a hold
        async_reset_pulse("async_mid_hold");
        step("after_reset_hold");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] addr;
            logic [31:0] instr;
            instr = $urandom;
            if ($urandom_range(0, 3) == 0) instr[25:21] = instr[20:16];
            case ($urandom_range(0, 3))
                0:       addr = m_instr[25:21];
                1:       addr = m_instr[20:16];
                2:       addr = 5'd0;
                default: addr = 5'($urandom_range(0, 31));
            endcase
            drive(instr, $urandom, $urandom, $urandom, TW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 1)), addr, $urandom);
            step("rand");
            if ($urandom_range(0, 99) == 0) async_reset_pulse("rand_async");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_d_e_pipe_reg
`default_nettype wire
